alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_sequencer_if.sv | 35 +++
 rtl/alu_lat_counter.sv | 27 ++
 rtl/alu_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: field positions, opcodes and FSM states.
package alu_pkg;

    localparam int INSTR_W = 32;
    localparam int OP_W    = 6;
    localparam int REG_W   = 6;
    localparam int DATA_W  = 16;
    localparam int RES_W   = 32;
    localparam int CNT_W   = 5;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS1_MSB = 25;
    localparam int RS1_LSB = 20;
    localparam int RS2_MSB = 19;
    localparam int RS2_LSB = 14;
    localparam int RD_MSB  = 13;
    localparam int RD_LSB  = 8;

    localparam logic [OP_W-1:0] OP_ADD  = 6'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 6'd1;
    localparam logic [OP_W-1:0] OP_NEG  = 6'd2;
    localparam logic [OP_W-1:0] OP_MUL  = 6'd3;
    localparam logic [OP_W-1:0] OP_DIV  = 6'd4;
    localparam logic [OP_W-1:0] OP_OR   = 6'd5;
    localparam logic [OP_W-1:0] OP_XOR  = 6'd6;
    localparam logic [OP_W-1:0] OP_NAND = 6'd7;
    localparam logic [OP_W-1:0] OP_NOR  = 6'd8;
    localparam logic [OP_W-1:0] OP_XNOR = 6'd9;
    localparam logic [OP_W-1:0] OP_NOT  = 6'd10;
    localparam logic [OP_W-1:0] OP_SHL  = 6'd11;
    localparam logic [OP_W-1:0] OP_SHR  = 6'd12;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_EXEC     = 3'd2,
        S_WB_LO    = 3'd3,
        S_WB_HI    = 3'd4,
        S_DONE_ERR = 3'd5
    } state_t;

    // Opcodes are dense from 0, so everything above SHR is illegal.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op <= OP_SHR);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, register-file ports and ALU ports of the sequencer.
// master = sequencer side, slave = requester / register file / ALU side.
interface alu_sequencer_if;
    import alu_pkg::*;

    logic                 instr_valid;
    logic                 instr_ready;
    logic [INSTR_W-1:0]   instr;
    logic [REG_W-1:0]     rf_raddr_a;
    logic [REG_W-1:0]     rf_raddr_b;
    logic [DATA_W-1:0]    rf_rdata_a;
    logic [DATA_W-1:0]    rf_rdata_b;
    logic [DATA_W-1:0]    alu_a;
    logic [DATA_W-1:0]    alu_b;
    logic [OP_W-1:0]      alu_op;
    logic [RES_W-1:0]     alu_res;
    logic                 rf_we;
    logic [REG_W-1:0]     rf_waddr;
    logic [DATA_W-1:0]    rf_wdata;
    logic                 done;
    logic                 err;

    modport master (
        input  instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_res,
        output instr_ready, rf_raddr_a, rf_raddr_b, alu_a, alu_b, alu_op,
               rf_we, rf_waddr, rf_wdata, done, err
    );

    modport slave (
        output instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_res,
        input  instr_ready, rf_raddr_a, rf_raddr_b, alu_a, alu_b, alu_op,
               rf_we, rf_waddr, rf_wdata, done, err
    );

endinterface

// File: rtl/alu_lat_counter.sv
// Loadable down-counter timing the EXEC phase; o_last flags the final EXEC cycle.
module alu_lat_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_last
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_last = (r_count == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer: read operands, hold EXEC for the op latency,
// then write back one (or two, for MUL) 16-bit results to the register file.
module alu_sequencer #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.master bus
);
    import alu_pkg::*;

    localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_MUL = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] L_DIV = CNT_W'(DIV_LAT);

    state_t             r_state;
    state_t             w_next;
    logic [OP_W-1:0]    r_op;
    logic [REG_W-1:0]   r_rdst;
    logic [REG_W-1:0]   r_raddr_a;
    logic [REG_W-1:0]   r_raddr_b;
    logic [DATA_W-1:0]  r_alu_a;
    logic [DATA_W-1:0]  r_alu_b;
    logic [RES_W-1:0]   r_result;

    logic               w_accept;
    logic               w_ready;
    logic               w_cnt_load;
    logic [CNT_W-1:0]   w_cnt_val;
    logic               w_cnt_en;
    logic               w_cnt_last;
    logic               w_we;
    logic [REG_W-1:0]   w_waddr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_done;
    logic               w_err;
    logic               w_unused;

    assign w_unused = ^bus.instr[RD_LSB-1:0];
    assign w_accept = bus.instr_valid && (r_state == S_IDLE);

    assign w_cnt_val = (r_op == OP_MUL) ? L_MUL :
                       (r_op == OP_DIV) ? L_DIV : L_ONE;

    alu_lat_counter #(.W(CNT_W)) u_lat_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_en       (w_cnt_en),
        .o_last     (w_cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_rdst    <= '0;
            r_raddr_a <= '0;
            r_raddr_b <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_result  <= '0;
        end else begin
            if (w_accept) begin
                r_op      <= bus.instr[OP_MSB:OP_LSB];
                r_raddr_a <= bus.instr[RS1_MSB:RS1_LSB];
                r_raddr_b <= bus.instr[RS2_MSB:RS2_LSB];
                r_rdst    <= bus.instr[RD_MSB:RD_LSB];
            end
            if (r_state == S_READ) begin
                r_alu_a <= bus.rf_rdata_a;
                r_alu_b <= bus.rf_rdata_b;
            end
            if ((r_state == S_EXEC) && w_cnt_last) begin
                r_result <= bus.alu_res;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_en   = 1'b0;
        w_we       = 1'b0;
        w_waddr    = '0;
        w_wdata    = '0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.instr_valid) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                // Divide-by-zero is detected on the raw read data, before EXEC starts.
                if (!op_legal(r_op)) begin
                    w_next = S_DONE_ERR;
                end else if ((r_op == OP_DIV) && (bus.rf_rdata_a == '0)) begin
                    w_next = S_DONE_ERR;
                end else begin
                    w_cnt_load = 1'b1;
                    w_next     = S_EXEC;
                end
            end
            S_EXEC: begin
                w_cnt_en = 1'b1;
                if (w_cnt_last) begin
                    w_next = S_WB_LO;
                end
            end
            S_WB_LO: begin
                w_we    = 1'b1;
                w_waddr = r_rdst;
                w_wdata = r_result[DATA_W-1:0];
                if (r_op == OP_MUL) begin
                    w_next = S_WB_HI;
                end else begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_WB_HI: begin
                w_we    = 1'b1;
                w_waddr = r_rdst + 6'd1;
                w_wdata = r_result[RES_W-1:DATA_W];
                w_done  = 1'b1;
                w_next  = S_IDLE;
            end
            S_DONE_ERR: begin
                w_done = 1'b1;
                w_err  = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.instr_ready = w_ready;
    assign bus.rf_raddr_a  = r_raddr_a;
    assign bus.rf_raddr_b  = r_raddr_b;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_op      = r_op;
    assign bus.rf_we       = w_we;
    assign bus.rf_waddr    = w_waddr;
    assign bus.rf_wdata    = w_wdata;
    assign bus.done        = w_done;
    assign bus.err         = w_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: vector table for single instructions plus
// hand-written sequences for back-to-back issue, held valid and mid-instruction reset.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_sequencer_if u_if();

    alu_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.master)
    );

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  rd;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] res;
        int          lat;
        logic        err;
        int          nwr;
        logic [5:0]  wa0;
        logic [15:0] wd0;
        logic [5:0]  wa1;
        logic [15:0] wd1;
    } vec_t;

    vec_t vecs[12];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] rs1,
                                       input logic [5:0] rs2, input logic [5:0] rd);
        return {op, rs1, rs2, rd, 8'hA5};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [15:0] ra,
                         input logic [15:0] rb, input logic [31:0] res);
        u_if.instr      = ins;
        u_if.rf_rdata_a = ra;
        u_if.rf_rdata_b = rb;
        u_if.alu_res    = res;
    endtask

    // Waits for IDLE at a falling edge, then offers the instruction for one accept.
    task automatic offer(input logic [31:0] ins, input logic [15:0] ra,
                         input logic [15:0] rb, input logic [31:0] res, input string nm);
        int waits;
        @(negedge clk);
        drive(ins, ra, rb, res);
        u_if.instr_valid = 1'b1;
        waits = 0;
        while (!u_if.instr_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        chk({nm, ".ready"}, {31'd0, u_if.instr_ready}, 32'd1);
        step();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        int done_cyc;
        logic err_at_done;
        int nwr;
        int stray_err;
        logic [5:0] wa[2];
        logic [15:0] wd[2];
        nm = $sformatf("v%0d", idx);
        done_cyc = -1;
        err_at_done = 1'bx;
        nwr = 0;
        stray_err = 0;
        wa[0] = '0; wa[1] = '0;
        wd[0] = '0; wd[1] = '0;
        offer(mk(v.op, v.rs1, v.rs2, v.rd), v.ra, v.rb, v.res, nm);
        u_if.instr_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 1) begin
                chk({nm, ".raddr"}, {20'd0, u_if.rf_raddr_a, u_if.rf_raddr_b}, {20'd0, v.rs1, v.rs2});
            end
            if (k == 2 && !v.err) begin
                chk({nm, ".alu_ab"}, {u_if.alu_a, u_if.alu_b}, {v.ra, v.rb});
                chk({nm, ".alu_op"}, {26'd0, u_if.alu_op}, {26'd0, v.op});
            end
            if (u_if.rf_we) begin
                if (nwr < 2) begin
                    wa[nwr] = u_if.rf_waddr;
                    wd[nwr] = u_if.rf_wdata;
                end
                nwr++;
            end
            if (u_if.err && !u_if.done) stray_err++;
            if (u_if.done) begin
                done_cyc = k;
                err_at_done = u_if.err;
                break;
            end
            step();
        end
        chk({nm, ".latency"}, done_cyc, v.lat);
        chk({nm, ".err"}, {31'd0, err_at_done}, {31'd0, v.err});
        chk({nm, ".nwrites"}, nwr, v.nwr);
        chk({nm, ".stray_err"}, stray_err, 0);
        if (v.nwr >= 1) chk({nm, ".wr0"}, {10'd0, wa[0], wd[0]}, {10'd0, v.wa0, v.wd0});
        if (v.nwr == 2) chk({nm, ".wr1"}, {10'd0, wa[1], wd[1]}, {10'd0, v.wa1, v.wd1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int ndone;
        int nwe;
        int acc_cyc;
        int done1;
        int done2;

        vecs[0]  = '{OP_ADD,  6'd2,  6'd3,  6'd4,  16'h0005, 16'h0007, 32'h0000_000C, 3,  1'b0, 1, 6'd4,  16'h000C, 6'd0, 16'h0000};
        vecs[1]  = '{OP_MUL,  6'd1,  6'd2,  6'd63, 16'h012C, 16'h014D, 32'h0001_86A0, 3 + MUL_LAT, 1'b0, 2, 6'd63, 16'h86A0, 6'd0, 16'h0001};
        vecs[2]  = '{OP_DIV,  6'd5,  6'd6,  6'd7,  16'h0000, 16'h0005, 32'h0000_1234, 2,  1'b1, 0, 6'd0,  16'h0000, 6'd0, 16'h0000};
        vecs[3]  = '{OP_DIV,  6'd8,  6'd9,  6'd10, 16'h0003, 16'h0009, 32'h0000_0003, 2 + DIV_LAT, 1'b0, 1, 6'd10, 16'h0003, 6'd0, 16'h0000};
        vecs[4]  = '{6'h3F,   6'd1,  6'd1,  6'd2,  16'h0001, 16'h0001, 32'h0000_0002, 2,  1'b1, 0, 6'd0,  16'h0000, 6'd0, 16'h0000};
        vecs[5]  = '{OP_XOR,  6'd11, 6'd12, 6'd7,  16'h00F0, 16'h0F0F, 32'hFFFF_1234, 3,  1'b0, 1, 6'd7,  16'h1234, 6'd0, 16'h0000};
        vecs[6]  = '{OP_NOT,  6'd13, 6'd14, 6'd0,  16'h00FF, 16'h0000, 32'h0000_FF00, 3,  1'b0, 1, 6'd0,  16'hFF00, 6'd0, 16'h0000};
        vecs[7]  = '{OP_SHR,  6'd15, 6'd16, 6'd62, 16'h8000, 16'h0001, 32'h0000_4000, 3,  1'b0, 1, 6'd62, 16'h4000, 6'd0, 16'h0000};
        vecs[8]  = '{6'd13,   6'd1,  6'd2,  6'd3,  16'h0004, 16'h0005, 32'h0000_0009, 2,  1'b1, 0, 6'd0,  16'h0000, 6'd0, 16'h0000};
        vecs[9]  = '{OP_SUB,  6'd21, 6'd22, 6'd3,  16'h0000, 16'h0004, 32'h0000_FFFC, 3,  1'b0, 1, 6'd3,  16'hFFFC, 6'd0, 16'h0000};
        vecs[10] = '{OP_MUL,  6'd17, 6'd18, 6'd5,  16'h0002, 16'h0003, 32'hABCD_0006, 3 + MUL_LAT, 1'b0, 2, 6'd5,  16'h0006, 6'd6, 16'hABCD};
        vecs[11] = '{OP_NAND, 6'd19, 6'd20, 6'd1,  16'hFFFF, 16'hFFFF, 32'h0000_0000, 3,  1'b0, 1, 6'd1,  16'h0000, 6'd0, 16'h0000};

        u_if.instr_valid = 1'b0;
        drive(32'd0, 16'd0, 16'd0, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst.ready", {31'd0, u_if.instr_ready}, 32'd1);
        chk("rst.we_done_err", {29'd0, u_if.rf_we, u_if.done, u_if.err}, 32'd0);
        chk("rst.alu", {u_if.alu_a, u_if.alu_b}, 32'd0);
        chk("rst.op_raddr", {14'd0, u_if.alu_op, u_if.rf_raddr_a, u_if.rf_raddr_b}, 32'd0);
        chk("rst.waddr_wdata", {10'd0, u_if.rf_waddr, u_if.rf_wdata}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        // Illegal op followed at once by an ADD with valid never dropped.
        offer(mk(6'h3F, 6'd1, 6'd2, 6'd3), 16'h0001, 16'h0002, 32'h0000_0042, "b2b");
        u_if.instr = mk(OP_ADD, 6'd1, 6'd2, 6'd9);
        chk("b2b.c1_done", {31'd0, u_if.done}, 32'd0);
        step();
        chk("b2b.c2_done_err", {30'd0, u_if.done, u_if.err}, 32'd3);
        chk("b2b.c2_we", {31'd0, u_if.rf_we}, 32'd0);
        step();
        chk("b2b.c3_ready", {31'd0, u_if.instr_ready}, 32'd1);
        step();
        u_if.instr_valid = 1'b0;
        chk("b2b.c4_ready", {31'd0, u_if.instr_ready}, 32'd0);
        step();
        step();
        chk("b2b.c6_wb", {u_if.rf_we, u_if.done, u_if.err, 7'd0, u_if.rf_waddr, u_if.rf_wdata},
            {1'b1, 1'b1, 1'b0, 7'd0, 6'd9, 16'h0042});

        // Valid held with a new instruction while a MUL is in flight.
        offer(mk(OP_MUL, 6'd1, 6'd2, 6'd20), 16'h0011, 16'h0022, 32'h0002_0003, "hold");
        u_if.instr = mk(OP_ADD, 6'd3, 6'd4, 6'd21);
        ndone = 0; nwe = 0; acc_cyc = -1; done1 = -1; done2 = -1;
        for (int k = 1; k <= 20; k++) begin
            if (u_if.rf_we) nwe++;
            if (u_if.done) begin
                ndone++;
                if (done1 < 0) done1 = k; else done2 = k;
            end
            if (u_if.instr_ready && u_if.instr_valid && acc_cyc < 0) acc_cyc = k;
            step();
            if (acc_cyc >= 0) u_if.instr_valid = 1'b0;
        end
        chk("hold.mul_done", done1, 3 + MUL_LAT);
        chk("hold.accept_cycle", acc_cyc, 4 + MUL_LAT);
        chk("hold.add_done", done2, 7 + MUL_LAT);
        chk("hold.ndone", ndone, 2);
        chk("hold.nwe", nwe, 3);

        // Reset pulse in the middle of MUL EXEC abandons the instruction.
        offer(mk(OP_MUL, 6'd7, 6'd8, 6'd30), 16'h1234, 16'h5678, 32'h1111_2222, "rstmid");
        u_if.instr_valid = 1'b0;
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid.outs", {29'd0, u_if.rf_we, u_if.done, u_if.err}, 32'd0);
        chk("rstmid.alu", {u_if.alu_a, u_if.alu_b}, 32'd0);
        chk("rstmid.op_raddr", {14'd0, u_if.alu_op, u_if.rf_raddr_a, u_if.rf_raddr_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rstmid.ready", {31'd0, u_if.instr_ready}, 32'd1);
        ndone = 0; nwe = 0;
        for (int k = 0; k < 20; k++) begin
            if (u_if.rf_we) nwe++;
            if (u_if.done) ndone++;
            step();
        end
        chk("rstmid.no_we", nwe, 0);
        chk("rstmid.no_done", ndone, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
